marquee_loader: RTL and testbench
=================================

MARQUEE_LOADER -- requirements
Module: marquee_loader

Interface
REQ-001 Parameter N, default 32, width of the assembled sequence; SHALL be a multiple of 4.
REQ-002 Parameter DEB_CYCLES, default 1_000_000, number of stable cycles required to accept a button edge; simulation value is 4.
REQ-003 sys_clk  input  1  single clock; all state is clocked on its rising edge.
REQ-004 sys_rst  input  1  reset; asynchronous, active-high.
REQ-005 btn_load  input  1  raw, bouncy load button; asynchronous to sys_clk.
REQ-006 btn_clr  input  1  raw clear button; asynchronous to sys_clk.
REQ-007 nibble  input  4  switch value to append; asynchronous to sys_clk.
REQ-008 run  input  1  user run switch; asynchronous to sys_clk.
REQ-009 seq  output  N  assembled sequence, newest nibble at bits [3:0]; feeds the marquee seq input.
REQ-010 digit_cnt  output  $clog2(N/4)+1  number of nibbles loaded, saturating at N/4.
REQ-011 seq_valid  output  1  high when digit_cnt == N/4.
REQ-012 enable  output  1  shift enable for the downstream marquee.

Function
REQ-013 btn_load, btn_clr, nibble and run SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 Load debounce FSM states: IDLE, PRESS, HELD, RELEASE.
REQ-015 IDLE -> PRESS when synced btn_load = 1; the debounce counter clears on entry.
REQ-016 PRESS -> IDLE if synced btn_load drops before the counter reaches DEB_CYCLES-1.
REQ-017 PRESS -> HELD when the counter reaches DEB_CYCLES-1 with btn_load still high; a single-cycle load_pulse SHALL be issued on that transition.
REQ-018 HELD -> RELEASE when synced btn_load = 0; RELEASE -> HELD if it returns high before DEB_CYCLES-1; RELEASE -> IDLE after DEB_CYCLES consecutive low cycles.
REQ-019 Exactly one load_pulse SHALL be produced per accepted press, however long the button is held and however much it bounces.
REQ-020 On load_pulse: seq <= {seq[N-5:0], synced nibble}; digit_cnt increments by 1, saturating at N/4.
REQ-021 Full condition: a load while digit_cnt == N/4 SHALL still shift, dropping the oldest nibble; digit_cnt and seq_valid stay unchanged.
REQ-022 Synced btn_clr = 1 SHALL set seq, digit_cnt and seq_valid to 0 on the next edge; the debounce FSM is unaffected.
REQ-023 If clear and load_pulse coincide, clear SHALL win and the nibble is discarded.
REQ-024 seq_valid SHALL be registered and update on the same edge as digit_cnt.
REQ-025 Latency: a clean press held at least DEB_CYCLES+3 cycles SHALL update seq exactly DEB_CYCLES+2 cycles after the rising edge of btn_load.
REQ-026 enable SHALL be combinational: synced run AND seq_valid.

Reset
REQ-027 While sys_rst = 1: seq = 0, digit_cnt = 0, seq_valid = 0, enable = 0, FSM = IDLE, counters and synchronizers = 0.
REQ-028 Reset asserted mid-debounce SHALL abort the press with no load_pulse; after release, loading restarts from IDLE.

Configuration
REQ-029 Macro LOADER_AUTOSTART_EN defined: enable = seq_valid, and the run input is ignored.
REQ-030 LOADER_AUTOSTART_EN undefined: enable = synced run AND seq_valid, as in REQ-026.

Verification
REQ-031 DEB_CYCLES=4; press btn_load 10 cycles with nibble=0xA -> one load_pulse; seq=0x0000000A, digit_cnt=1 at rising edge + 6 cycles.
REQ-032 Eight presses with nibbles 1..8 -> seq=0x12345678, digit_cnt=8, seq_valid=1; with run=1, enable=1.
REQ-033 Ninth press with nibble=9 -> seq=0x23456789, digit_cnt stays 8.
REQ-034 btn_load toggling every 2 cycles for 20 cycles, then held 10 cycles -> exactly one load.
REQ-035 btn_clr pulsed in the same cycle as a load_pulse -> seq=0, digit_cnt=0, seq_valid=0.
REQ-036 sys_rst asserted 2 cycles into PRESS -> no load; all outputs 0; the next clean press loads normally.

Source files
------------

// File: rtl/marquee_loader.sv
// marquee_loader
//   Assembles a sequence of 4-bit digits, entered one at a time from switches
//   with a bouncy push button, into an N-bit word that drives a marquee.
//
//   Ports
//     sys_clk    in   1            single clock, rising edge
//     sys_rst    in   1            asynchronous, active-high reset
//     btn_load   in   1            raw load button (bouncy, asynchronous)
//     btn_clr    in   1            raw clear button (asynchronous)
//     nibble     in   4            digit to append (asynchronous)
//     run        in   1            run switch (asynchronous)
//     seq        out  N            assembled sequence, newest digit at [3:0]
//     digit_cnt  out  clog2(N/4)+1 digits loaded, saturating at N/4
//     seq_valid  out  1            registered, high when digit_cnt == N/4
//     enable     out  1            shift enable for the downstream marquee
//
//   Build option
//     LOADER_AUTOSTART_EN  when defined, enable = seq_valid and run is unused.
module marquee_loader #(
  parameter int N          = 32,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  btn_load,
  input  logic                  btn_clr,
  input  logic [3:0]            nibble,
  input  logic                  run,
  output logic [N-1:0]          seq,
  output logic [$clog2(N/4):0]  digit_cnt,
  output logic                  seq_valid,
  output logic                  enable
);

  localparam int CW = $clog2(N/4) + 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] FULL     = CW'(N / 4);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  // Two-flop synchronizers
  logic       r_load_s1, r_load_s2;
  logic       r_clr_s1, r_clr_s2;
  logic [3:0] r_nib_s1, r_nib_s2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_load_s1 <= 1'b0;
      r_load_s2 <= 1'b0;
      r_clr_s1  <= 1'b0;
      r_clr_s2  <= 1'b0;
      r_nib_s1  <= '0;
      r_nib_s2  <= '0;
    end else begin
      r_load_s1 <= btn_load;
      r_load_s2 <= r_load_s1;
      r_clr_s1  <= btn_clr;
      r_clr_s2  <= r_clr_s1;
      r_nib_s1  <= nibble;
      r_nib_s2  <= r_nib_s1;
    end
  end

  // Load-button debounce FSM
  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_load_pulse;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load_pulse = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_load_s2) begin
          w_state_nxt = PRESS;
          w_cnt_nxt   = '0;
        end
      end
      PRESS: begin
        if (!r_load_s2) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == DEB_LAST) begin
          // Only exit from PRESS to HELD, so one pulse per accepted press.
          w_state_nxt  = HELD;
          w_load_pulse = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!r_load_s2) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        if (r_load_s2) begin
          w_state_nxt = HELD;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequence assembly; clear takes priority over a coincident load.
  logic [N-1:0]  r_seq;
  logic [CW-1:0] r_digit_cnt;
  logic          r_seq_valid;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_digit_cnt + 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_seq       <= '0;
      r_digit_cnt <= '0;
      r_seq_valid <= 1'b0;
    end else if (r_clr_s2) begin
      r_seq       <= '0;
      r_digit_cnt <= '0;
      r_seq_valid <= 1'b0;
    end else if (w_load_pulse) begin
      r_seq <= {r_seq[N-5:0], r_nib_s2};
      if (r_digit_cnt != FULL) begin
        r_digit_cnt <= w_cnt_inc;
        r_seq_valid <= (w_cnt_inc == FULL);
      end
    end
  end

  assign seq       = r_seq;
  assign digit_cnt = r_digit_cnt;
  assign seq_valid = r_seq_valid;

`ifdef LOADER_AUTOSTART_EN
  assign enable = r_seq_valid;
`else
  logic r_run_s1, r_run_s2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
    end else begin
      r_run_s1 <= run;
      r_run_s2 <= r_run_s1;
    end
  end

  assign enable = r_run_s2 & r_seq_valid;
`endif

endmodule

// File: tb/tb_marquee_loader.sv
module tb_marquee_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        btn_load, btn_clr, run;
  logic [3:0]  nibble;
  logic [31:0] seq;
  logic [3:0]  digit_cnt;
  logic        seq_valid, enable;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] s;
    logic [3:0]  c;
    logic        v;
    int          at;
  } exp_t;

  exp_t q[$];

  marquee_loader #(.N(32), .DEB_CYCLES(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .btn_load  (btn_load),
    .btn_clr   (btn_clr),
    .nibble    (nibble),
    .run       (run),
    .seq       (seq),
    .digit_cnt (digit_cnt),
    .seq_valid (seq_valid),
    .enable    (enable)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [3:0] c, input logic v, input int at);
    exp_t e;
    e.s = s; e.c = c; e.v = v; e.at = at;
    q.push_back(e);
  endtask

  // Clean press: the edge after this negedge first samples the button, and
  // the load lands six edges after that sample.
  task automatic press(input logic [3:0] nib, input logic [31:0] es,
                       input logic [3:0] ec, input logic ev);
    @(negedge sys_clk);
    nibble   = nib;
    btn_load = 1'b1;
    push(es, ec, ev, cyc + 7);
    repeat (10) @(negedge sys_clk);
    btn_load = 1'b0;
    repeat (12) @(negedge sys_clk);
  endtask

  task automatic clear_pulse();
    @(negedge sys_clk);
    btn_clr = 1'b1;
    push('0, '0, 1'b0, cyc + 3);
    @(negedge sys_clk);
    btn_clr = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  // Monitor: any change in the visible state is an output event.
  initial begin
    logic [31:0] p_seq;
    logic [3:0]  p_cnt;
    logic        p_val;
    exp_t        e;
    p_seq = '0;
    p_cnt = '0;
    p_val = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (seq !== p_seq || digit_cnt !== p_cnt || seq_valid !== p_val) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_update @%0d: seq=%h cnt=%0d valid=%0b, expected no change",
                   cyc, seq, digit_cnt, seq_valid);
        end else begin
          e = q.pop_front();
          if (seq !== e.s || digit_cnt !== e.c || seq_valid !== e.v || cyc != e.at) begin
            n_fail++;
            $display("FAIL update: got seq=%h cnt=%0d valid=%0b @%0d, expected seq=%h cnt=%0d valid=%0b @%0d",
                     seq, digit_cnt, seq_valid, cyc, e.s, e.c, e.v, e.at);
          end
        end
        p_seq = seq;
        p_cnt = digit_cnt;
        p_val = seq_valid;
      end else if (q.size() > 0 && q[0].at < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_update @%0d: seq=%h, expected seq=%h @%0d",
                 cyc, seq, q[0].s, q[0].at);
        void'(q.pop_front());
      end
    end
  end

  logic [31:0] tbl [8];

  initial begin
    int c0;
    tbl = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12345,
            32'h123456, 32'h1234567, 32'h12345678};
    sys_rst  = 1'b1;
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    run      = 1'b0;
    nibble   = 4'h0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_seq", seq, 32'h0);
    chk("rst_cnt", {28'h0, digit_cnt}, 32'h0);
    chk("rst_valid", {31'h0, seq_valid}, 32'h0);
    chk("rst_enable", {31'h0, enable}, 32'h0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Single press with latency check
    press(4'hA, 32'h0000000A, 4'd1, 1'b0);
    clear_pulse();

    // Fill to N/4 digits
    for (int i = 0; i < 8; i++)
      press(4'(i + 1), tbl[i], 4'(i + 1), (i == 7));
    chk("enable_run0", {31'h0, enable}, 32'h0);
    @(negedge sys_clk);
    run = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("enable_run1", {31'h0, enable}, 32'h1);

    // Load while full: shift, count stays
    press(4'h9, 32'h23456789, 4'd8, 1'b1);

    // Bouncing button, then a steady hold: exactly one load
    @(negedge sys_clk);
    nibble = 4'hB;
    for (int i = 0; i < 5; i++) begin
      btn_load = 1'b1;
      repeat (2) @(negedge sys_clk);
      btn_load = 1'b0;
      repeat (2) @(negedge sys_clk);
    end
    btn_load = 1'b1;
    push(32'h3456789B, 4'd8, 1'b1, cyc + 7);
    repeat (10) @(negedge sys_clk);
    btn_load = 1'b0;
    repeat (12) @(negedge sys_clk);

    // Clear lands on the same edge as the load pulse: clear wins
    @(negedge sys_clk);
    nibble   = 4'hC;
    btn_load = 1'b1;
    c0 = cyc;
    push('0, '0, 1'b0, c0 + 7);
    repeat (4) @(negedge sys_clk);
    btn_clr = 1'b1;
    @(negedge sys_clk);
    btn_clr = 1'b0;
    repeat (5) @(negedge sys_clk);
    btn_load = 1'b0;
    repeat (12) @(negedge sys_clk);
    chk("enable_after_clr", {31'h0, enable}, 32'h0);

    // Reset two cycles into PRESS aborts the press
    @(negedge sys_clk);
    nibble   = 4'hD;
    btn_load = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst  = 1'b1;
    btn_load = 1'b0;
    #1;
    chk("midrst_seq", seq, 32'h0);
    chk("midrst_cnt", {28'h0, digit_cnt}, 32'h0);
    chk("midrst_valid", {31'h0, seq_valid}, 32'h0);
    chk("midrst_enable", {31'h0, enable}, 32'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (12) @(negedge sys_clk);
    press(4'hE, 32'h0000000E, 4'd1, 1'b0);

    repeat (10) @(negedge sys_clk);
    chk("queue_drained", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
